// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs mnemonic + fields into 32-bit MIPS words and writes them to imem sequentially
//   clk, rst_n             clock, async active-low reset
//   clear                  sync restart of pointer and sticky error
//   in_valid/in_ready      field-bundle handshake
//   mnem, rs, rt, rd, shamt, funct, imm, target   instruction fields
//   imem_we/addr/wdata     one-cycle imem write port
//   word_count, full       words written, pointer at DEPTH
//   err, err_sticky        illegal-mnemonic pulse and latched flag
module mips_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic              err_sticky
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;
  logic [5:0] op;
  logic [31:0] enc;
  logic fire, legal;
  assign full = word_count == (ADDR_W+1)'(DEPTH);
  assign in_ready = state == IDLE && !full;
  assign fire = in_valid && in_ready;
  assign legal = !mnem[3];
  always_comb begin
    op = mnem == 4'd1 ? 6'd35 :
         mnem == 4'd2 ? 6'd43 :
         mnem == 4'd3 ? 6'd4  :
         mnem == 4'd4 ? 6'd2  :
         mnem == 4'd5 ? 6'd3  :
         mnem == 4'd6 ? 6'd8  :
         mnem == 4'd7 ? 6'd13 : 6'd0;
    enc = mnem == 4'd0 ? {6'd0, rs, rt, rd, shamt, funct} :
          (mnem == 4'd4 || mnem == 4'd5) ? {op, target} : {op, rs, rt, imm};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err <= fire && !legal;
      if (fire && !legal) err_sticky <= 1'b1;
      if (state == WRITE) begin
        state      <= IDLE;
        imem_we    <= 1'b0;
        word_count <= word_count + 1'b1;
      end else if (fire && legal) begin
        state      <= WRITE;
        imem_we    <= 1'b1;
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= enc;
      end
    end
  end
endmodule
